// File: rtl/logic_result_fifo_if.sv
// Valid/ready bundle for the bitwise-result FIFO: operand side in, result side out.
interface logic_result_fifo_if #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = 16
) ();
  logic                       in_valid;
  logic                       in_ready;
  logic [Width-1:0]           in_a;
  logic [Width-1:0]           in_b;
  logic [1:0]                 in_op;
  logic                       out_valid;
  logic                       out_ready;
  logic [Width-1:0]           out_data;
  logic                       out_zero;
  logic                       out_ones;
  logic [$clog2(Depth):0]     count;
  logic [CntW-1:0]            stall_cycles;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_ones, count, stall_cycles
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_ones, count, stall_cycles
  );
endinterface

// File: rtl/logic_result_fifo.sv
// Evaluates AND/OR/XOR/NOR on each accepted operand pair and queues the result
// with zero/all-ones flags; counts cycles where upstream is held off.
module logic_result_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  logic_result_fifo_if.slave bus
);
  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = PtrW + 1;

  // Entry layout: {ones, zero, data}
  logic [Width+1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [CntW-1:0]   stall_q, stall_d;
  logic [Width-1:0]  result;
  logic [Width+1:0]  head;
  logic              full, empty, push, pop;

  always_comb begin
    result = '0;
    unique case (bus.in_op)
      2'b00: result = bus.in_a & bus.in_b;
      2'b01: result = bus.in_a | bus.in_b;
      2'b10: result = bus.in_a ^ bus.in_b;
      2'b11: result = ~(bus.in_a | bus.in_b);
      default: result = '0;
    endcase
  end

  assign full  = (count_q == CountW'(Depth));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid & ~full;
  assign pop   = ~empty & bus.out_ready;

  // Storage is never reset, so the head is gated to zero while empty.
  assign head             = mem_q[rd_ptr_q];
  assign bus.in_ready     = ~full;
  assign bus.out_valid    = ~empty;
  assign bus.out_data     = empty ? '0 : head[Width-1:0];
  assign bus.out_zero     = ~empty & head[Width];
  assign bus.out_ones     = ~empty & head[Width+1];
  assign bus.count        = count_q;
  assign bus.stall_cycles = stall_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      stall_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CountW'(1);
      else if (!push && pop) count_d = count_q - CountW'(1);
      if (bus.in_valid && full && (stall_q != '1)) stall_d = stall_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mem_q[wr_ptr_q] <= {&result, ~|result, result};
    end
  end
endmodule

// File: tb/tb_logic_result_fifo.sv
// Directed bench for logic_result_fifo; expected values are hand-computed.
module tb_logic_result_fifo;
  logic clk_i;
  logic rst_ni;
  logic clear_i;
  int   n_assert;
  int   n_fail;

  logic_result_fifo_if #(.Width(32), .Depth(4), .CntW(16)) bus ();

  logic_result_fifo #(.Width(32), .Depth(4), .CntW(16)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .bus     (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_ni        = 1'b0;
    clear_i       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 2'b00;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_ni = 1'b1;

    // 1: idle after reset
    tick();
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_count", 32'(bus.count), 32'd0);
    chk("idle_out_data", bus.out_data, 32'h0);
    chk("idle_flags", {30'd0, bus.out_ones, bus.out_zero}, 32'd0);
    chk("idle_stall", 32'(bus.stall_cycles), 32'd0);

    // 2: OR results pop in order
    push(32'h0000FF00, 32'h00000000, 2'b01);
    chk("or_first_visible", 32'(bus.out_valid), 32'd1);
    push(32'h11111111, 32'h00000000, 2'b01);
    chk("or_count2", 32'(bus.count), 32'd2);
    chk("or_head0", bus.out_data, 32'h0000FF00);
    chk("or_zero0", 32'(bus.out_zero), 32'd0);
    pop();
    chk("or_head1", bus.out_data, 32'h11111111);
    chk("or_zero1", 32'(bus.out_zero), 32'd0);
    pop();
    chk("or_empty", 32'(bus.out_valid), 32'd0);
    chk("or_empty_data", bus.out_data, 32'h0);

    // 3: stored zero / all-ones flags
    push(32'h00000000, 32'hFFFFFFFF, 2'b00);
    push(32'h00000000, 32'h00000000, 2'b11);
    chk("and_head", bus.out_data, 32'h00000000);
    chk("and_zero", 32'(bus.out_zero), 32'd1);
    chk("and_ones", 32'(bus.out_ones), 32'd0);
    pop();
    chk("nor_head", bus.out_data, 32'hFFFFFFFF);
    chk("nor_ones", 32'(bus.out_ones), 32'd1);
    chk("nor_zero", 32'(bus.out_zero), 32'd0);
    pop();

    // 4: fill, stall three cycles, drain
    bus.in_valid = 1'b1;
    bus.in_b     = 32'hF0F0F0F0;
    bus.in_op    = 2'b10;
    for (int i = 0; i < 4; i++) begin
      bus.in_a = 32'(i);
      tick();
    end
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.in_a = 32'hDEAD0000 + 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stall_3", 32'(bus.stall_cycles), 32'd3);
    chk("full_hold_count", 32'(bus.count), 32'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("xor_pop%0d", i), bus.out_data, 32'hF0F0F0F0 + 32'(i));
      tick();
      if (i == 0) chk("ready_after_pop", 32'(bus.in_ready), 32'd1);
    end
    bus.out_ready = 1'b0;
    chk("drain_empty", 32'(bus.out_valid), 32'd0);

    // 5: streaming push+pop across pointer wrap
    push(32'd100, 32'd0, 2'b01);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in_a  = 32'd200 + 32'(k);
      bus.in_b  = 32'd0;
      bus.in_op = 2'b01;
      chk($sformatf("stream_data%0d", k), bus.out_data, (k == 0) ? 32'd100 : 32'd199 + 32'(k));
      chk($sformatf("stream_count%0d", k), 32'(bus.count), 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stream_last", bus.out_data, 32'd209);
    tick();
    bus.out_ready = 1'b0;
    chk("stream_empty", 32'(bus.count), 32'd0);
    chk("stream_stall", 32'(bus.stall_cycles), 32'd3);

    // 6: synchronous clear beats a same-cycle push
    push(32'h1, 32'h0, 2'b01);
    push(32'h2, 32'h0, 2'b01);
    chk("pre_clear_count", 32'(bus.count), 32'd2);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h3;
    clear_i      = 1'b1;
    tick();
    clear_i      = 1'b0;
    bus.in_valid = 1'b0;
    chk("clear_count", 32'(bus.count), 32'd0);
    chk("clear_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clear_stall", 32'(bus.stall_cycles), 32'd0);
    tick();
    chk("clear_not_stored", 32'(bus.count), 32'd0);

    // Asynchronous reset mid-stream empties without a clock edge
    push(32'h4, 32'h0, 2'b01);
    push(32'h5, 32'h0, 2'b01);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_count", 32'(bus.count), 32'd0);
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_out_data", bus.out_data, 32'h0);
    rst_ni = 1'b1;
    tick();
    push(32'h0F, 32'hF0, 2'b10);
    chk("resume_data", bus.out_data, 32'hFF);
    chk("resume_count", 32'(bus.count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
